// File: rtl/ibex_register_file_mp_if.sv
// ibex_register_file_mp_if
//  Port bundle of the multi-ported register file.
//  master : the ID stage / issue logic (drives addresses, write data, enables, wipe request)
//  slave  : the register file (returns read data, wipe status, conflict flag, parity errors)
//  Signals:
//   raddr_i       NumRead*AddrWidth   read addresses, port r at [r*AddrWidth +: AddrWidth]
//   rdata_o       NumRead*DataWidth   read data, same packing
//   waddr_i       NumWrite*AddrWidth  write addresses
//   wdata_i       NumWrite*DataWidth  write data
//   we_i          NumWrite            write enables
//   clear_req_i   1                   wipe request
//   clear_busy_o  1                   wipe in progress
//   clear_done_o  1                   wipe finished (1-cycle pulse)
//   wr_conflict_o 1                   same-address multi-write seen last cycle
//   parity_err_o  NumRead             per-port parity error
//   perr_inject_i NumWrite            invert stored parity of a write
interface ibex_register_file_mp_if #(
   parameter int unsigned NumRead   = 2,
   parameter int unsigned NumWrite  = 2,
   parameter int unsigned AddrWidth = 5,
   parameter int unsigned DataWidth = 32
) ();

   logic [NumRead*AddrWidth-1:0]  raddr_i;
   logic [NumRead*DataWidth-1:0]  rdata_o;
   logic [NumWrite*AddrWidth-1:0] waddr_i;
   logic [NumWrite*DataWidth-1:0] wdata_i;
   logic [NumWrite-1:0]           we_i;
   logic                          clear_req_i;
   logic                          clear_busy_o;
   logic                          clear_done_o;
   logic                          wr_conflict_o;
   logic [NumRead-1:0]            parity_err_o;
   logic [NumWrite-1:0]           perr_inject_i;

   modport master (
      output raddr_i, waddr_i, wdata_i, we_i, clear_req_i, perr_inject_i,
      input  rdata_o, clear_busy_o, clear_done_o, wr_conflict_o, parity_err_o
   );

   modport slave (
      input  raddr_i, waddr_i, wdata_i, we_i, clear_req_i, perr_inject_i,
      output rdata_o, clear_busy_o, clear_done_o, wr_conflict_o, parity_err_o
   );

endinterface

// File: rtl/ibex_register_file_mp.sv
// ibex_register_file_mp
//  Flop-based register file with NumRead combinational read ports and NumWrite write
//  ports (higher port index wins on a same-address collision), optional write-to-read
//  bypass, hardwired-zero word 0 and a one-word-per-cycle secure-wipe engine.
//  Ports:
//   clk_i  clock
//   rst_i  synchronous active-high reset (clears all words, aborts a wipe)
//   rf     ibex_register_file_mp_if.slave: read/write ports, wipe control/status,
//          write-conflict flag, parity error / inject
//  Build option: define RF_PARITY_EN to store and check an even-parity bit per word.
module ibex_register_file_mp #(
   parameter int unsigned NumRead   = 2,
   parameter int unsigned NumWrite  = 2,
   parameter int unsigned AddrWidth = 5,
   parameter int unsigned DataWidth = 32,
   parameter bit          Bypass    = 1'b1,
   parameter bit          ZeroReg0  = 1'b1
) (
   input logic                    clk_i,
   input logic                    rst_i,
   ibex_register_file_mp_if.slave rf
);

   localparam int unsigned NumWords = 32'd1 << AddrWidth;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLEAR,
      S_DONE
   } state_e;

   state_e                 state_q;
   logic [AddrWidth-1:0]   ptr_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   conflict_q;
   logic [DataWidth-1:0]   mem_q [NumWords];

   logic                   wr_allowed_c;
   logic [NumWords-1:0]    wen_c;
   logic [DataWidth-1:0]   wval_c [NumWords];
   logic                   wr_conflict_c;

`ifdef RF_PARITY_EN
   logic [NumWords-1:0]    par_q;
   logic [NumWords-1:0]    wpar_c;
`else
   logic                   unused_perr_inject;
   assign unused_perr_inject = ^rf.perr_inject_i;
`endif

   // Writes are frozen for the whole wipe sweep
   assign wr_allowed_c = (state_q != S_CLEAR);

   // Per-word write decode; scanning ports upward lets the highest index win
   always_comb begin
      wen_c = '0;
`ifdef RF_PARITY_EN
      wpar_c = '0;
`endif
      for (int unsigned a = 0; a < NumWords; a++) begin
         wval_c[a] = '0;
         for (int unsigned w = 0; w < NumWrite; w++) begin
            if (rf.we_i[w] &&
                rf.waddr_i[w*AddrWidth +: AddrWidth] == AddrWidth'(a) &&
                !(ZeroReg0 && a == 0)) begin
               wen_c[a]  = 1'b1;
               wval_c[a] = rf.wdata_i[w*DataWidth +: DataWidth];
`ifdef RF_PARITY_EN
               wpar_c[a] = (^rf.wdata_i[w*DataWidth +: DataWidth]) ^ rf.perr_inject_i[w];
`endif
            end
         end
      end
   end

   // Two enabled ports hitting the same storable address in a cycle that accepts writes
   always_comb begin
      wr_conflict_c = 1'b0;
      for (int unsigned i = 0; i < NumWrite; i++) begin
         for (int unsigned j = i + 1; j < NumWrite; j++) begin
            if (wr_allowed_c && rf.we_i[i] && rf.we_i[j] &&
                rf.waddr_i[i*AddrWidth +: AddrWidth] == rf.waddr_i[j*AddrWidth +: AddrWidth] &&
                !(ZeroReg0 && rf.waddr_i[i*AddrWidth +: AddrWidth] == '0)) begin
               wr_conflict_c = 1'b1;
            end
         end
      end
   end

   // Read ports: word 0 forced to zero first, then bypass, then stored contents
   for (genvar r = 0; r < NumRead; r++) begin : g_rd
      logic [AddrWidth-1:0] ra;
      logic                 hit;
      logic [DataWidth-1:0] bdata;
      logic [DataWidth-1:0] rd;

      assign ra = rf.raddr_i[r*AddrWidth +: AddrWidth];

      always_comb begin
         hit   = 1'b0;
         bdata = '0;
         for (int unsigned w = 0; w < NumWrite; w++) begin
            if (wr_allowed_c && rf.we_i[w] && rf.waddr_i[w*AddrWidth +: AddrWidth] == ra) begin
               hit   = 1'b1;
               bdata = rf.wdata_i[w*DataWidth +: DataWidth];
            end
         end
      end

`ifdef RF_PARITY_EN
      logic pe;

      always_comb begin
         rd = mem_q[ra];
         pe = par_q[ra] ^ (^mem_q[ra]);
         if (ZeroReg0 && ra == '0) begin
            rd = '0;
            pe = 1'b0;
         end else if (Bypass && hit) begin
            // Parity of a bypassed word is recomputed from wdata, so it is always clean
            rd = bdata;
            pe = 1'b0;
         end
      end

      assign rf.parity_err_o[r] = pe;
`else
      always_comb begin
         rd = mem_q[ra];
         if (ZeroReg0 && ra == '0) begin
            rd = '0;
         end else if (Bypass && hit) begin
            rd = bdata;
         end
      end
`endif

      assign rf.rdata_o[r*DataWidth +: DataWidth] = rd;
   end

`ifndef RF_PARITY_EN
   assign rf.parity_err_o = '0;
`endif

   // Storage, wipe FSM and registered status
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         conflict_q <= 1'b0;
         for (int unsigned a = 0; a < NumWords; a++) begin
            mem_q[a] <= '0;
         end
`ifdef RF_PARITY_EN
         par_q <= '0;
`endif
      end else begin
         conflict_q <= wr_conflict_c;
         done_q     <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (rf.clear_req_i) begin
                  state_q <= S_CLEAR;
                  ptr_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            S_CLEAR: begin
               mem_q[ptr_q] <= '0;
`ifdef RF_PARITY_EN
               par_q[ptr_q] <= 1'b0;
`endif
               ptr_q <= ptr_q + AddrWidth'(1);
               if (ptr_q == AddrWidth'(NumWords - 1)) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               // Requests arriving here are dropped
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase

         if (wr_allowed_c) begin
            for (int unsigned a = 0; a < NumWords; a++) begin
               if (wen_c[a]) begin
                  mem_q[a] <= wval_c[a];
`ifdef RF_PARITY_EN
                  par_q[a] <= wpar_c[a];
`endif
               end
            end
         end
      end
   end

   assign rf.clear_busy_o  = busy_q;
   assign rf.clear_done_o  = done_q;
   assign rf.wr_conflict_o = conflict_q;

endmodule
